line_fill_scheduler: RTL and testbench
======================================

Name: line_fill_scheduler

Overview:
- Sequences the renderer into the 1024-entry single-line VGA line buffer.
- On each VGA line-end blanking interval it requests the next scan line from the renderer and accepts pixels over a valid/ready handshake.
- Drives the buffer's x/data write port and detects underruns (line not filled before the next line end).
- Sits between the renderer and the VGA output stage, which consumes x_out/data_out as its x_in/data_in.

Parameters:
- LINE_WIDTH, 1024, pixels per line; also the write-address range.
- NUM_LINES, 768, visible lines per frame; line counter wraps at this value.
- X_WIDTH, 10, width of the x write address.
- Y_WIDTH, 10, width of the line number.
- DATA_WIDTH, 12, pixel width (4:4:4 RGB).
- UNDERRUN_CNT_WIDTH, 8, width of the saturating underrun counter.

Ports:
- CLK  in  1  base clock (100 MHz); sole clock.
- RST  in  1  reset, asynchronous, active-high.
- enable_in  in  1  permits new line requests; a line already in progress always completes.
- lineend_in  in  1  level, high during end-of-line blanking from the VGA timing generator.
- render_start_out  out  1  one-cycle pulse requesting line render_y_out.
- render_y_out  out  Y_WIDTH  line number being requested or filled.
- pix_valid_in  in  1  renderer pixel valid.
- pix_data_in  in  DATA_WIDTH  renderer pixel.
- pix_ready_out  out  1  scheduler accepts a pixel this cycle.
- wr_en_out  out  1  line-buffer write strobe.
- x_out  out  X_WIDTH  line-buffer write address.
- data_out  out  DATA_WIDTH  line-buffer write data.
- busy_out  out  1  high in REQ or FILL.
- underrun_out  out  1  sticky underrun flag.
- underrun_cnt_out  out  UNDERRUN_CNT_WIDTH  saturating underrun count.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; line_cnt=0; x_cnt=0.
  - The lineend_in edge-detect register is cleared.
  - Reset may assert in any state; the in-flight line is abandoned with no write issued.
- Edge detect: le_rise = lineend_in & ~le_q, where le_q is a registered copy of lineend_in. Only rising edges act.
- State machine:
  - IDLE:
    - On le_rise with enable_in=1, go to REQ.
    - Otherwise stay. le_rise with enable_in=0 is ignored and line_cnt does not advance.
  - REQ:
    - render_start_out=1 for exactly this cycle; render_y_out=line_cnt; x_cnt cleared to 0.
    - Go to FILL next cycle.
  - FILL:
    - pix_ready_out=1.
    - On accept (pix_valid_in & pix_ready_out), capture x_cnt and pix_data_in and increment x_cnt.
    - When accepting with x_cnt==LINE_WIDTH-1:
      - Go to DONE.
      - line_cnt increments, wrapping from NUM_LINES-1 to 0.
  - DONE:
    - pix_ready_out=0.
    - Go to IDLE on the next cycle. lineend_in may still be high, but no edge is seen, so no double request occurs.
- Write port timing:
  - wr_en_out, x_out and data_out are registered, with 1-cycle latency after an accept.
  - wr_en_out=0 on every other cycle; x_out and data_out hold their last value.
- Handshake:
  - pix_ready_out is a registered function of state only, with no combinational path from pix_valid_in.
  - pix_valid_in without ready is ignored; the renderer must hold its data.
- Underrun: le_rise while in REQ or FILL:
  - underrun_out is set and sticky until RST.
  - underrun_cnt_out increments and saturates at all-ones.
  - The current line is abandoned and line_cnt advances with wrap.
  - If enable_in=1, go to REQ for the new line_cnt. Otherwise go to IDLE.
  - An accept in the same cycle is still written, but x_cnt is then reset by REQ.
- Simultaneous le_rise and the final accept in FILL: the fill is complete, so there is no underrun. Go to DONE as normal; this le_rise is consumed and no new request is made.
- Frame wrap: after line NUM_LINES-1 completes, render_y_out of the next request is 0.
- Widths: x_cnt is X_WIDTH bits and must not overflow because it is compared against LINE_WIDTH-1. line_cnt is compared against NUM_LINES-1 before increment.

Decomposition:
- Shared package `render_pkg`:
  - Constants LINE_WIDTH, NUM_LINES, X_WIDTH, Y_WIDTH, DATA_WIDTH.
  - State encoding typedef (IDLE, REQ, FILL, DONE).
  - Pixel type (DATA_WIDTH-bit RGB).
- Sub-module `wrap_counter` (parameterised modulus, enable, clear, wrap flag), instantiated for x_cnt and line_cnt.
- Edge detect and the underrun counter stay inline.

Test Plan:
- Reset, enable_in=1, lineend_in rising edge, renderer always valid with data=x[11:0]:
  - render_start_out pulses once with render_y_out=0.
  - 1024 writes, x_out 0..1023 with data_out=x_out, each 1 cycle after accept.
  - DONE then IDLE; line_cnt=1.
- Renderer valid toggling every other cycle:
  - Exactly 1024 writes, addresses contiguous with no gaps or duplicates.
  - pix_ready_out never depends on pix_valid_in.
- Second le_rise after only 500 pixels accepted:
  - underrun_out=1; underrun_cnt_out=1.
  - New render_start_out with render_y_out=1.
  - x_out restarts at 0.
- 768 complete lines, then a further le_rise:
  - Request carries render_y_out=0 (frame wrap).
  - underrun_out stays 0 throughout.
- enable_in=0 with 3 le_rise events:
  - No render_start_out; line_cnt unchanged.
  - Deassert enable mid-FILL: the line still completes all 1024 writes.
- RST asserted asynchronously mid-FILL at x_cnt=300:
  - All outputs 0 immediately; no wr_en_out until the next REQ.
  - Next request carries render_y_out=0.
- 300 forced underruns: underrun_cnt_out saturates at 255.

Source files
------------

// File: rtl/render_pkg.sv
// Shared constants and types for the renderer-to-line-buffer path.
package render_pkg;
  localparam int LINE_WIDTH         = 1024;
  localparam int NUM_LINES          = 768;
  localparam int X_WIDTH            = 10;
  localparam int Y_WIDTH            = 10;
  localparam int DATA_WIDTH         = 12;
  localparam int UNDERRUN_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  // Debug view: FSM state plus the single-cycle frame-wrap strobe.
  typedef struct packed {
    state_t state;
    logic   line_wrap;
  } dbg_t;
endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with synchronous clear; o_wrap flags an enabled step off the last value.
module wrap_counter #(
  parameter int MODULUS = 1024,
  parameter int WIDTH   = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_wrap
);
  logic [WIDTH-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == WIDTH'(MODULUS - 1));
  assign o_wrap   = i_en & w_at_max;
  assign o_cnt    = r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/line_fill_scheduler.sv
// Requests one scan line per line-end blanking edge and streams accepted pixels
// into the single-line buffer write port, flagging lines not filled in time.
module line_fill_scheduler #(
  parameter int LINE_WIDTH         = render_pkg::LINE_WIDTH,
  parameter int NUM_LINES          = render_pkg::NUM_LINES,
  parameter int X_WIDTH            = render_pkg::X_WIDTH,
  parameter int Y_WIDTH            = render_pkg::Y_WIDTH,
  parameter int DATA_WIDTH         = render_pkg::DATA_WIDTH,
  parameter int UNDERRUN_CNT_WIDTH = render_pkg::UNDERRUN_CNT_WIDTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          enable_in,
  input  logic                          lineend_in,
  output logic                          render_start_out,
  output logic [Y_WIDTH-1:0]            render_y_out,
  input  logic                          pix_valid_in,
  input  logic [DATA_WIDTH-1:0]         pix_data_in,
  output logic                          pix_ready_out,
  output logic                          wr_en_out,
  output logic [X_WIDTH-1:0]            x_out,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          busy_out,
  output logic                          underrun_out,
  output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_cnt_out,
  output render_pkg::dbg_t              dbg_out
);
  import render_pkg::*;

  state_t                        r_state;
  state_t                        w_next;
  logic                          r_le_q;
  logic                          w_le_rise;
  logic                          w_accept;
  logic                          w_last_px;
  logic                          w_underrun;
  logic                          w_line_wrap;
  logic [X_WIDTH-1:0]            w_x_cnt;
  logic [Y_WIDTH-1:0]            w_line_cnt;
  logic                          r_wr_en;
  logic [X_WIDTH-1:0]            r_x;
  logic [DATA_WIDTH-1:0]         r_data;
  logic                          r_underrun;
  logic [UNDERRUN_CNT_WIDTH-1:0] r_ucnt;

  // Handshake: a pixel transfers on a cycle where pix_valid_in and pix_ready_out
  // are both high; ready depends only on registered state, and the renderer must
  // hold valid and data stable until that transfer happens.
  assign w_le_rise     = lineend_in & ~r_le_q;
  assign pix_ready_out = (r_state == ST_FILL);
  assign w_accept      = pix_valid_in & pix_ready_out;

  // A line-end edge landing on the final accept counts as completion, not underrun.
  assign w_underrun = w_le_rise &
                      ((r_state == ST_REQ) | ((r_state == ST_FILL) & ~w_last_px));

  wrap_counter #(.MODULUS(LINE_WIDTH), .WIDTH(X_WIDTH)) u_x_cnt (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_en   (w_accept),
    .i_clr  (r_state == ST_REQ),
    .o_cnt  (w_x_cnt),
    .o_wrap (w_last_px)
  );

  wrap_counter #(.MODULUS(NUM_LINES), .WIDTH(Y_WIDTH)) u_line_cnt (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_en   (w_last_px | w_underrun),
    .i_clr  (1'b0),
    .o_cnt  (w_line_cnt),
    .o_wrap (w_line_wrap)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_le_rise && enable_in) w_next = ST_REQ;
      ST_REQ:  w_next = w_underrun ? (enable_in ? ST_REQ : ST_IDLE) : ST_FILL;
      ST_FILL: begin
        if (w_last_px)       w_next = ST_DONE;
        else if (w_underrun) w_next = enable_in ? ST_REQ : ST_IDLE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_le_q     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_x        <= '0;
      r_data     <= '0;
      r_underrun <= 1'b0;
      r_ucnt     <= '0;
    end else begin
      r_state <= w_next;
      r_le_q  <= lineend_in;
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_x    <= w_x_cnt;
        r_data <= pix_data_in;
      end
      if (w_underrun) begin
        r_underrun <= 1'b1;
        if (~&r_ucnt) r_ucnt <= r_ucnt + 1'b1;
      end
    end
  end

  assign render_start_out  = (r_state == ST_REQ);
  assign render_y_out      = w_line_cnt;
  assign busy_out          = (r_state == ST_REQ) | (r_state == ST_FILL);
  assign wr_en_out         = r_wr_en;
  assign x_out             = r_x;
  assign data_out          = r_data;
  assign underrun_out      = r_underrun;
  assign underrun_cnt_out  = r_ucnt;
  assign dbg_out.state     = r_state;
  assign dbg_out.line_wrap = w_line_wrap;
endmodule

// File: tb/tb_line_fill_scheduler.sv
// Randomised bench for line_fill_scheduler with a line-level reference model and scoreboard.
module tb_line_fill_scheduler;
  localparam int LW = 32;
  localparam int NL = 6;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int DW = 12;
  localparam int UW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable_in = 1'b0;
  logic lineend_in = 1'b0;
  logic pix_valid_in = 1'b0;
  logic [DW-1:0] pix_data_in = '0;
  logic render_start_out, pix_ready_out, wr_en_out, busy_out, underrun_out;
  logic [YW-1:0] render_y_out;
  logic [XW-1:0] x_out;
  logic [DW-1:0] data_out;
  logic [UW-1:0] underrun_cnt_out;
  render_pkg::dbg_t dbg;

  int checks = 0;
  int errors = 0;
  int mode = 0;

  // reference model: line-level view of what the scheduler should be doing
  logic [XW+DW-1:0] exp_wr_q[$];
  logic [YW-1:0]    exp_req_q[$];
  bit m_active = 0;
  int m_px = 0;
  int m_line = 0;
  int m_under = 0;
  bit prev_le = 0;
  bit last_acc = 0;

  line_fill_scheduler #(
    .LINE_WIDTH(LW), .NUM_LINES(NL), .X_WIDTH(XW), .Y_WIDTH(YW),
    .DATA_WIDTH(DW), .UNDERRUN_CNT_WIDTH(UW)
  ) dut (
    .CLK(clk), .RST(rst), .enable_in(enable_in), .lineend_in(lineend_in),
    .render_start_out(render_start_out), .render_y_out(render_y_out),
    .pix_valid_in(pix_valid_in), .pix_data_in(pix_data_in),
    .pix_ready_out(pix_ready_out), .wr_en_out(wr_en_out), .x_out(x_out),
    .data_out(data_out), .busy_out(busy_out), .underrun_out(underrun_out),
    .underrun_cnt_out(underrun_cnt_out), .dbg_out(dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model update: pre-edge inputs decide accepts, line-end edges and underruns.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_px = 0; m_line = 0; m_under = 0;
      prev_le = 0; last_acc = 0;
      exp_wr_q.delete();
      exp_req_q.delete();
    end else begin
      bit rise, acc, fin;
      rise = lineend_in && !prev_le;
      prev_le = lineend_in;
      acc = pix_valid_in && pix_ready_out;
      last_acc = acc;
      fin = 0;
      if (acc) begin
        check("accept_in_line", {31'd0, m_active}, 32'd1);
        exp_wr_q.push_back({XW'(m_px), pix_data_in});
        m_px++;
        if (m_px == LW) begin
          fin = 1;
          m_active = 0;
          m_line = (m_line + 1) % NL;
        end
      end
      if (rise && !fin) begin
        if (m_active) begin
          if (m_under < 255) m_under++;
          m_line = (m_line + 1) % NL;
          m_px = 0;
          m_active = enable_in;
          if (enable_in) exp_req_q.push_back(YW'(m_line));
        end else if (enable_in) begin
          m_active = 1;
          m_px = 0;
          exp_req_q.push_back(YW'(m_line));
        end
      end
    end
  end

  // Renderer driver: holds valid/data while a pixel is pending.
  always @(negedge clk) begin
    if (!(pix_valid_in && !last_acc)) begin
      case (mode)
        0: pix_valid_in = 1'b1;
        1: pix_valid_in = !pix_valid_in;
        default: pix_valid_in = ($urandom_range(0, 3) != 0);
      endcase
      pix_data_in = DW'($urandom);
    end
  end

  // Monitor: pops expected requests and writes whenever the DUT presents them.
  always @(negedge clk) begin
    if (render_start_out) begin
      checks++;
      if (exp_req_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_request actual_y=%0d required=none", render_y_out);
      end else begin
        logic [YW-1:0] ey;
        ey = exp_req_q.pop_front();
        if (render_y_out !== ey) begin
          errors++;
          $display("FAIL request_y actual=%0d required=%0d", render_y_out, ey);
        end
      end
    end
    if (wr_en_out) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual_x=%0d required=none", x_out);
      end else begin
        logic [XW+DW-1:0] ew;
        ew = exp_wr_q.pop_front();
        if ({x_out, data_out} !== ew) begin
          errors++;
          $display("FAIL write actual_x=%0d data=%0h required_x=%0d data=%0h",
                   x_out, data_out, ew[XW+DW-1:DW], ew[DW-1:0]);
        end
      end
    end
    if (pix_ready_out) begin
      checks++;
      if (!m_active) begin
        errors++;
        $display("FAIL ready_outside_line actual=1 required=0");
      end
    end
  end

  task automatic pulse_le(input int hi);
    @(negedge clk);
    lineend_in = 1'b1;
    repeat (hi) @(negedge clk);
    lineend_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < LW * 8 + 50; i++) begin
      @(negedge clk);
      if (!m_active && exp_wr_q.size() == 0 && exp_req_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL line_done_timeout actual=pending required=complete");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_px(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < LW * 8 + 50; i++) begin
      @(negedge clk);
      if (m_px >= n) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pixel_wait_timeout actual=%0d required=%0d", m_px, n);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, {31'd0, render_start_out}, 0);
    check({tag, "_y"}, {22'd0, render_y_out}, 0);
    check({tag, "_ready"}, {31'd0, pix_ready_out}, 0);
    check({tag, "_wr_en"}, {31'd0, wr_en_out}, 0);
    check({tag, "_x"}, {22'd0, x_out}, 0);
    check({tag, "_data"}, {20'd0, data_out}, 0);
    check({tag, "_busy"}, {31'd0, busy_out}, 0);
    check({tag, "_underrun"}, {31'd0, underrun_out}, 0);
    check({tag, "_ucnt"}, {24'd0, underrun_cnt_out}, 0);
    check({tag, "_state"}, {30'd0, dbg.state}, {30'd0, render_pkg::ST_IDLE});
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    enable_in = 1'b1;

    // line 0 with a renderer that is always valid
    mode = 0;
    pulse_le(2);
    wait_done();
    check("line0_idle_state", {30'd0, dbg.state}, {30'd0, render_pkg::ST_IDLE});
    check("line0_busy", {31'd0, busy_out}, 0);
    check("line0_next_y", {22'd0, render_y_out}, 1);

    // line 1 with valid toggling every other cycle
    mode = 1;
    pulse_le(1);
    wait_done();

    // rest of the frame, ending at the wrap point
    mode = 2;
    for (int l = 2; l < NL; l++) begin
      pulse_le($urandom_range(1, 3));
      wait_done();
    end
    check("frame_wrap_y", {22'd0, render_y_out}, 0);
    pulse_le(1);
    wait_done();
    check("no_underrun_full_frame", {31'd0, underrun_out}, 0);

    // line-end edges while disabled are ignored
    enable_in = 1'b0;
    for (int k = 0; k < 3; k++) pulse_le(2);
    check("disabled_y_hold", {22'd0, render_y_out}, YW'(m_line));
    check("disabled_idle", {31'd0, busy_out}, 0);

    // disabling mid-line still completes the line
    enable_in = 1'b1;
    pulse_le(1);
    repeat (4) @(negedge clk);
    enable_in = 1'b0;
    wait_done();
    enable_in = 1'b1;

    // line-end edge coinciding with the final accept is not an underrun
    mode = 0;
    pulse_le(1);
    wait_px(LW - 1);
    lineend_in = 1'b1;
    repeat (2) @(negedge clk);
    lineend_in = 1'b0;
    wait_done();
    check("coincident_no_underrun", {24'd0, underrun_cnt_out}, 32'(m_under));
    check("coincident_idle", {30'd0, dbg.state}, {30'd0, render_pkg::ST_IDLE});

    // a second edge mid-line abandons the line
    mode = 2;
    pulse_le(1);
    repeat (LW / 2) @(negedge clk);
    pulse_le(1);
    wait_done();
    check("underrun_flag", {31'd0, underrun_out}, 1);
    check("underrun_count", {24'd0, underrun_cnt_out}, 32'(m_under));

    // asynchronous reset in the middle of a fill
    mode = 0;
    pulse_le(1);
    wait_px(LW / 2);
    #2 rst = 1'b1;
    #1 check_all_zero("midfill_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse_le(1);
    wait_done();

    // back-to-back edges saturate the underrun counter
    mode = 2;
    for (int k = 0; k < 301; k++) pulse_le(1);
    wait_done();
    check("underrun_saturate", {24'd0, underrun_cnt_out}, 255);
    check("underrun_sticky", {31'd0, underrun_out}, 1);

    check("req_queue_drained", exp_req_q.size(), 0);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
